// File: rtl/dmem_arbiter.sv
// Shared-BRAM arbiter: CPU data port vs debug/loader port, with starvation bound and debug lock.
// Latency: grant in the request cycle (combinational); read data/valid one cycle after the grant.
// Backpressure: a denied requester sees gnt=0 (CPU also sees cpu_stall) and must hold its request.
//
// Ports: clk/rst (async, active-high); cpu_* and dbg_* request ports with gnt/rvalid/rdata
// returns; dbg_lock requests exclusive ownership; mem_* drives DataMemory, mem_rdata comes back.

package riscv_pkg;
    localparam int XLEN = 32;
    localparam int ALEN = 32;
endpackage

module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    // CPU data port
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [ALEN-1:0] cpu_addr,
    input  logic [XLEN-1:0] cpu_wdata,
    input  logic [3:0]      cpu_be,
    input  logic [2:0]      cpu_funct3,
    output logic            cpu_gnt,
    output logic            cpu_stall,
    output logic            cpu_rvalid,
    output logic [XLEN-1:0] cpu_rdata,
    // debug / loader port
    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [ALEN-1:0] dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    input  logic [3:0]      dbg_be,
    input  logic [2:0]      dbg_funct3,
    input  logic            dbg_lock,
    output logic            dbg_gnt,
    output logic            dbg_rvalid,
    output logic [XLEN-1:0] dbg_rdata,
    // DataMemory side
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [2:0]      mem_funct3,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic [ALEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      be;
        logic [2:0]      funct3;
    } mem_req_t;

    state_t          state;
    logic [WW-1:0]   wait_cnt;
    logic            rd_cpu;
    logic            rd_dbg;
    logic            cpu_win;
    logic            dbg_win;
    mem_req_t        cpu_fields;
    mem_req_t        dbg_fields;
    mem_req_t        sel_fields;

    // Raw arbitration decision; reset gating is applied on the outputs below.
    always_comb begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
        if (state == ST_LOCKED) begin
            dbg_win = dbg_req;
        end else if (dbg_req && (wait_cnt == WAIT_LIMIT)) begin
            // Debug has waited long enough: it beats the CPU this cycle.
            dbg_win = 1'b1;
        end else if (cpu_req) begin
            cpu_win = 1'b1;
        end else if (dbg_req) begin
            dbg_win = 1'b1;
        end
    end

    assign cpu_gnt   = cpu_win & ~rst;
    assign dbg_gnt   = dbg_win & ~rst;
    assign cpu_stall = cpu_req & ~cpu_gnt & ~rst;

    // Address/data path follows the CPU unless debug holds the grant, so an
    // idle or reset cycle still presents the CPU fields to the BRAM.
    assign cpu_fields = '{addr: cpu_addr, wdata: cpu_wdata, be: cpu_be, funct3: cpu_funct3};
    assign dbg_fields = '{addr: dbg_addr, wdata: dbg_wdata, be: dbg_be, funct3: dbg_funct3};
    assign sel_fields = dbg_gnt ? dbg_fields : cpu_fields;

    assign mem_addr   = sel_fields.addr;
    assign mem_wdata  = sel_fields.wdata;
    assign mem_be     = sel_fields.be;
    assign mem_funct3 = sel_fields.funct3;
    assign mem_we     = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we);

    // BRAM read data is shared; the registered tags say whose read it is.
    assign cpu_rvalid = rd_cpu;
    assign dbg_rvalid = rd_dbg;
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_ARB;
            wait_cnt <= '0;
            rd_cpu   <= 1'b0;
            rd_dbg   <= 1'b0;
        end else begin
            case (state)
                ST_ARB:    if (dbg_gnt && dbg_lock) state <= ST_LOCKED;
                ST_LOCKED: if (!dbg_lock)           state <= ST_ARB;
                default:                            state <= ST_ARB;
            endcase

            // Counts consecutive denied debug cycles; any grant or withdrawn request restarts it.
            if (!dbg_req || dbg_gnt) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            rd_cpu <= cpu_gnt & ~cpu_we;
            rd_dbg <= dbg_gnt & ~dbg_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import riscv_pkg::*;

    localparam int MW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [ALEN-1:0] cpu_addr;
    logic [XLEN-1:0] cpu_wdata, cpu_rdata;
    logic [3:0]      cpu_be;
    logic [2:0]      cpu_funct3;
    logic            dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
    logic [ALEN-1:0] dbg_addr;
    logic [XLEN-1:0] dbg_wdata, dbg_rdata;
    logic [3:0]      dbg_be;
    logic [2:0]      dbg_funct3;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [2:0]      mem_funct3;
    logic [ALEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_bad = 0;

    dmem_arbiter #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be), .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_be(dbg_be), .dbg_funct3(dbg_funct3), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM with byte enables, driven only by the DUT's mem_* outputs.
    logic [XLEN-1:0] bram [0:255];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) bram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        mem_rdata <= bram[mem_addr[9:2]];
    end

    // Reference model state: who owns memory, how long debug has been refused,
    // what read result is due next cycle, and the memory contents it implies.
    logic [XLEN-1:0] ref_mem [0:255];
    bit              m_locked;
    int              m_denied;
    bit              m_pc, m_pd;
    logic [XLEN-1:0] m_pdata;
    bit              last_cg, last_dg;
    logic            obs_cg, obs_dg, obs_st, obs_we, obs_crv, obs_drv;
    logic [XLEN-1:0] obs_crd, obs_drd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_denied = 0; m_pc = 0; m_pd = 0; last_cg = 0; last_dg = 0;
    endtask

    // Called at a negedge with inputs already set; checks this cycle, commits the model, returns at next negedge.
    task automatic step();
        bit              eg_c, eg_d, ewe;
        logic [ALEN-1:0] ea;
        logic [XLEN-1:0] ew;
        logic [3:0]      eb;
        logic [2:0]      ef;
        #1;
        if (m_locked) begin
            eg_d = dbg_req;
            eg_c = 0;
        end else begin
            eg_d = dbg_req && (m_denied >= MW || !cpu_req);
            eg_c = cpu_req && !eg_d;
        end
        if (eg_d) begin ea = dbg_addr; ew = dbg_wdata; eb = dbg_be; ef = dbg_funct3; end
        else      begin ea = cpu_addr; ew = cpu_wdata; eb = cpu_be; ef = cpu_funct3; end
        ewe = (eg_c && cpu_we) || (eg_d && dbg_we);

        obs_cg = cpu_gnt; obs_dg = dbg_gnt; obs_st = cpu_stall; obs_we = mem_we;
        obs_crv = cpu_rvalid; obs_drv = dbg_rvalid; obs_crd = cpu_rdata; obs_drd = dbg_rdata;

        check_eq("cpu_gnt", cpu_gnt, eg_c);
        check_eq("dbg_gnt", dbg_gnt, eg_d);
        check_eq("cpu_stall", cpu_stall, cpu_req && !eg_c);
        check_eq("mem_we", mem_we, ewe);
        check_eq("mem_addr", mem_addr, ea);
        check_eq("mem_wdata", mem_wdata, ew);
        check_eq("mem_be", mem_be, eb);
        check_eq("mem_funct3", mem_funct3, ef);
        check_eq("cpu_rvalid", cpu_rvalid, m_pc);
        check_eq("dbg_rvalid", dbg_rvalid, m_pd);
        if (m_pc) check_eq("cpu_rdata", cpu_rdata, m_pdata);
        if (m_pd) check_eq("dbg_rdata", dbg_rdata, m_pdata);

        @(posedge clk);
        m_pc = eg_c && !cpu_we;
        m_pd = eg_d && !dbg_we;
        m_pdata = ref_mem[ea[9:2]];
        if (ewe)
            for (int b = 0; b < 4; b++)
                if (eb[b]) ref_mem[ea[9:2]][8*b +: 8] = ew[8*b +: 8];
        m_locked = m_locked ? dbg_lock : (eg_d && dbg_lock);
        m_denied = (dbg_req && !eg_d) ? ((m_denied < MW) ? m_denied + 1 : MW) : 0;
        last_cg = eg_c;
        last_dg = eg_d;
        @(negedge clk);
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [ALEN-1:0] a, input logic [XLEN-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_be = 4'hF; cpu_funct3 = 3'b010;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [ALEN-1:0] a, input logic [XLEN-1:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_be = 4'hF; dbg_funct3 = 3'b010;
    endtask

    // Random traffic that honours the hold-until-granted rule.
    task automatic rand_inputs();
        if (!(cpu_req && !last_cg)) begin
            cpu_req    = ($urandom_range(0, 9) < 7);
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = ALEN'($urandom_range(0, 63)) << 2;
            cpu_wdata  = XLEN'($urandom);
            cpu_be     = 4'($urandom);
            cpu_funct3 = 3'($urandom);
        end
        if (!(dbg_req && !last_dg)) begin
            dbg_req    = ($urandom_range(0, 9) < 4);
            dbg_we     = 1'($urandom_range(0, 1));
            dbg_addr   = ALEN'($urandom_range(0, 63)) << 2;
            dbg_wdata  = XLEN'($urandom);
            dbg_be     = 4'($urandom);
            dbg_funct3 = 3'($urandom);
        end
        if ($urandom_range(0, 15) == 0) dbg_lock = ~dbg_lock;
    endtask

    initial begin
        rst = 1'b1;
        set_cpu(1, 1, 32'h8, 32'h5);
        set_dbg(1, 1, 32'hC, 32'h6);
        dbg_lock = 1'b0;
        model_reset();
        #2;
        check_eq("rst_cpu_gnt", cpu_gnt, 0);
        check_eq("rst_dbg_gnt", dbg_gnt, 0);
        check_eq("rst_stall", cpu_stall, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_cpu_rvalid", cpu_rvalid, 0);
        check_eq("rst_dbg_rvalid", dbg_rvalid, 0);
        check_eq("rst_mem_addr", mem_addr, 32'h8);
        @(negedge clk);
        rst = 1'b0;
        set_dbg(0, 0, 0, 0);

        // Give every word a known value.
        for (int i = 0; i < 64; i++) begin
            set_cpu(1, 1, ALEN'(i) << 2, 32'h1000 + XLEN'(i));
            step();
        end

        // CPU only: store then load the same word.
        set_cpu(1, 1, 32'h4, 32'h0000000A);
        step();
        check_eq("co_sw_gnt", obs_cg, 1);
        check_eq("co_sw_stall", obs_st, 0);
        set_cpu(1, 0, 32'h4, 0);
        step();
        check_eq("co_lw_gnt", obs_cg, 1);
        set_cpu(0, 0, 0, 0);
        step();
        check_eq("co_rvalid", obs_crv, 1);
        check_eq("co_rdata", obs_crd, 32'h0000000A);
        check_eq("co_dbg_rvalid", obs_drv, 0);

        // Read tagging.
        set_cpu(1, 1, 32'h10, 32'h11); step();
        set_cpu(1, 1, 32'h20, 32'h22); step();
        set_cpu(1, 0, 32'h10, 0);
        set_dbg(1, 0, 32'h20, 0);
        step();
        check_eq("tag_n_cgnt", obs_cg, 1);
        set_cpu(0, 0, 0, 0);
        step();
        check_eq("tag_n1_dgnt", obs_dg, 1);
        check_eq("tag_n1_crv", obs_crv, 1);
        check_eq("tag_n1_crd", obs_crd, 32'h11);
        check_eq("tag_n1_drv", obs_drv, 0);
        set_dbg(0, 0, 0, 0);
        step();
        check_eq("tag_n2_drv", obs_drv, 1);
        check_eq("tag_n2_drd", obs_drd, 32'h22);
        check_eq("tag_n2_crv", obs_crv, 0);

        // Idle.
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("idle_we", obs_we, 0);
            check_eq("idle_rv", obs_crv | obs_drv, 0);
        end

        // Contention: dbg wins once every MW+1 cycles.
        set_cpu(1, 0, 32'h0, 0);
        set_dbg(1, 0, 32'h4, 0);
        for (int i = 0; i < 2 * (MW + 1); i++) begin
            step();
            check_eq("cont_dgnt", obs_dg, (i % (MW + 1)) == MW);
            check_eq("cont_stall", obs_st, (i % (MW + 1)) == MW);
        end
        set_cpu(0, 0, 0, 0);
        set_dbg(0, 0, 0, 0);
        step();

        // Lock burst.
        dbg_lock = 1'b1;
        set_dbg(1, 1, 32'h40, 32'h100);
        step();
        check_eq("lk_first_dgnt", obs_dg, 1);
        set_cpu(1, 0, 32'h40, 0);
        for (int i = 1; i < 16; i++) begin
            set_dbg(1, 1, 32'h40 + ALEN'(4 * i), 32'h100 + XLEN'(i));
            step();
            check_eq("lk_cgnt", obs_cg, 0);
            check_eq("lk_stall", obs_st, 1);
        end
        dbg_lock = 1'b0;
        set_dbg(0, 0, 0, 0);
        step();
        check_eq("lk_drop_cgnt", obs_cg, 0);
        step();
        check_eq("lk_after_cgnt", obs_cg, 1);
        set_cpu(0, 0, 0, 0);
        step();
        check_eq("lk_rd_rv", obs_crv, 1);
        check_eq("lk_rd_data", obs_crd, 32'h100);

        // Reset while locked with a debug read outstanding.
        dbg_lock = 1'b1;
        set_dbg(1, 0, 32'h44, 0);
        step();
        rst = 1'b1;
        set_cpu(1, 0, 32'h44, 0);
        set_dbg(1, 1, 32'h48, 32'hDEAD);
        #1;
        check_eq("rl_cgnt", cpu_gnt, 0);
        check_eq("rl_dgnt", dbg_gnt, 0);
        check_eq("rl_we", mem_we, 0);
        check_eq("rl_crv", cpu_rvalid, 0);
        check_eq("rl_drv", dbg_rvalid, 0);
        check_eq("rl_addr", mem_addr, 32'h44);
        @(negedge clk);
        rst = 1'b0;
        dbg_lock = 1'b0;
        set_dbg(0, 0, 0, 0);
        model_reset();
        step();
        check_eq("rl_after_cgnt", obs_cg, 1);
        set_cpu(0, 0, 0, 0);
        step();
        check_eq("rl_after_rd", obs_crd, 32'h101);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
